ptp_rx_parser_v2: RTL and testbench
===================================

# ptp_rx_parser_v2

Parametrised PTP receive parser that sits between the port comparator and the PTP control / transmit / cycle-sync logic. It buffers incoming packet flits and per-packet valid flags in internal FIFOs. For each valid PTP packet it extracts the lookup key and message type, and computes residence-corrected timestamps in the split {coarse, sub-modulus} timestamp format. Compared with its predecessor, it tolerates packets that are only partly buffered, always drains to the packet tail, and reports truncated packets. It also exposes per-type and error statistics, and has a configurable timestamp modulus and FIFO depth.

## Interface
- W_PKT, 134: flit width; [W_PKT-1:W_PKT-2] is the tag: 01 = head, 11 = middle, 10 = tail
- TS_W, 48: timestamp width
- SUB_W, 17: width of the low (sub-modulus) timestamp field
- SUB_MOD, 125000: modulus of the low field; every low field must be < SUB_MOD
- FIFO_AW, 8: data FIFO address width, giving a depth of 2^FIFO_AW flits; the valid FIFO depth is 2^(FIFO_AW-2)
- READY_TH, 192: data FIFO occupancy at which inptp_ready drops
- PORT_W, 6: in_port field width
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- inptp_data_wr  in  1  flit write strobe
- inptp_data  in  W_PKT  flit
- inptp_valid_wr  in  1  per-packet flag write strobe
- inptp_valid  in  1  1 = parse this packet, 0 = discard it
- inptp_ready  out  1  high while data FIFO occupancy < READY_TH
- timer  in  TS_W  local time
- key  out  PORT_W+48  {SMAC, in_port}
- key_valid  out  1  one-cycle pulse
- ptp_recv_type  out  4  message type
- ptp_recv_type_valid  out  1  one-cycle pulse
- ts_2_record  out  1  one-cycle pulse on type 1
- ts_1, ts_1_valid  out  TS_W, 1  corrected origin time (type 1)
- ts_4_time, ts_4_time_wr  out  TS_W, 1  timer minus correction (type 3)
- ts_4, ts_4_valid  out  TS_W, 1  raw origin field (type 4)
- cnt_t1, cnt_t3, cnt_t4, cnt_drop, cnt_err  out  32 each  saturating counters
- ovf_err  out  1  sticky; set by a write to a full FIFO

## Operation
- Both FIFOs are show-ahead: q is the head entry whenever the FIFO is non-empty. A write to a full FIFO is ignored and sets ovf_err.
- Each parse state pops exactly one flit, and only in a cycle where the data FIFO is non-empty. Otherwise the state holds (stall).
- States and transitions:
  - IDLE: when the valid FIFO is non-empty, pop it and go to META0 if the flag is 1, or DISCARD if it is 0.
  - META0 (flit 0): latch meta_ts=[47:0] and in_port=[PORT_W+119:120]; capture rx_timer=timer in the same cycle.
  - META1 (flit 1): ignored.
  - ETH (flit 2): latch SMAC=[79:32] and type=[11:8]. Compute md = rx_timer ⊖ meta_ts. Types 1 and 3 pulse key_valid and ptp_recv_type_valid; type 1 also pulses ts_2_record. Increment cnt_t1, cnt_t3 or cnt_t4 as appropriate.
  - PTP1 (flit 3): corr = md ⊕ {[79:33],[32:16]}.
  - PTP2 (flit 4): ignored.
  - PTP3 (flit 5): origin = {[95:65],[64:48]}.
    - Type 1: ts_1 = corr ⊕ origin.
    - Type 3: ts_4_time = rx_timer ⊖ corr.
    - Type 4: ts_4 = origin; pulse ptp_recv_type_valid together with ts_4_valid.
    - Other types: no output.
  - After PTP3: if the flit popped at PTP3 was the tail, go to IDLE; otherwise go to DRAIN.
  - DRAIN / DISCARD: pop until the tail is popped, then go to IDLE. DISCARD increments cnt_drop once per packet.
- Truncation: a tail popped in META0..PTP2 aborts the parse. Go to IDLE, increment cnt_err, and suppress any further result pulses for that packet. Pulses already issued at ETH stand.
- ⊖ (modular subtract): if a.lo ≥ b.lo, result = {a.hi−b.hi, a.lo−b.lo}; else {a.hi−b.hi−1, a.lo+SUB_MOD−b.lo}.
- ⊕ (modular add): compute s = a.lo+b.lo in SUB_W+1 bits; if s ≥ SUB_MOD, result = {a.hi+b.hi+1, s−SUB_MOD}; else {a.hi+b.hi, s}.
- The hi field is TS_W−SUB_W bits wide and wraps modulo 2^(TS_W−SUB_W).

## Timing
- Reset (synchronous, checked every cycle): all outputs and counters go to 0, inptp_ready goes to 1, the FSM goes to IDLE, and both FIFOs are flushed. This applies mid-packet; the partial packet is lost and is not counted.
- Pulses are registered and appear in the cycle after the popping state; each pulse lasts exactly one cycle.
- Data outputs (ts_1, ts_4_time, ts_4, key, ptp_recv_type) hold their value until the next update.
- With a whole packet buffered and the valid flag popped in cycle 0:
  - META0 in cycle 1, ETH in cycle 3.
  - key_valid in cycle 4.
  - PTP3 in cycle 6; result pulse in cycle 7.
  - IDLE is re-entered in the cycle after the tail is popped.
- Throughput: 1 flit/cycle. There is one idle cycle (IDLE) between packets.
- inptp_ready is combinational from occupancy. Occupancy includes a write and a pop in the same cycle as a net change of 0.

## Test plan
- Type 1:
  - Stimulus: meta {10,1000}, timer {10,1500}, CF {0,200}, origin {5,124500}.
  - Required: ts_1={6,200} in cycle 7; key_valid and ts_2_record in cycle 4; cnt_t1=1.
- Type 3 with borrow:
  - Stimulus: meta {20,124000}, timer {21,100}, CF 0.
  - Required: ts_4_time={20,124000}; ts_4_time_wr pulses once.
- Discard:
  - Stimulus: 4-flit packet with valid=0, then a type-4 packet with origin {7,3}.
  - Required: no pulses for the first packet; cnt_drop=1; then ts_4={7,3} with ts_4_valid and ptp_recv_type_valid in the same cycle.
- Stall and drain:
  - Stimulus: type-1 packet of 8 flits, with 3 empty cycles inserted before flit 4.
  - Required: same ts_1 as the unstalled case, delayed by 3 cycles; all 8 flits popped before IDLE.
- Truncation:
  - Stimulus: type-3 packet whose tail is flit 3, followed by a good type-1 packet.
  - Required: key_valid once, no ts_4_time_wr, cnt_err=1; the second packet is parsed correctly.
- Overflow and reset:
  - Stimulus: write 2^FIFO_AW+1 flits with no reads, then assert reset mid-packet.
  - Required: inptp_ready=0 once occupancy reaches 192; ovf_err=1 until reset; after reset every output and counter is 0 and inptp_ready=1.

Source files
------------

// File: rtl/ptp_rx_parser_v2.sv
`default_nettype none
// ============================================================================
// Module   : ptp_rx_parser_v2
// Purpose  : PTP receive parser. Buffers packet flits and per-packet parse
//            flags in show-ahead FIFOs, walks each packet flit by flit,
//            extracts the lookup key and message type, and produces
//            residence-corrected timestamps in {coarse, sub-modulus} format.
//            Partly buffered packets stall, every packet drains to its tail,
//            and packets that end early are counted as truncated.
// Ports    : clk, reset              - clock, synchronous active-high reset
//            inptp_data_wr/inptp_data - flit write
//            inptp_valid_wr/inptp_valid - per-packet parse/discard flag write
//            inptp_ready             - data FIFO below READY_TH
//            timer                   - local time
//            key/key_valid, ptp_recv_type/ptp_recv_type_valid, ts_2_record
//            ts_1/ts_1_valid, ts_4_time/ts_4_time_wr, ts_4/ts_4_valid
//            cnt_t1, cnt_t3, cnt_t4, cnt_drop, cnt_err - saturating counters
//            ovf_err                 - sticky FIFO overflow flag
// Revision : 2.0 - initial release of the v2 parser
// ============================================================================
module ptp_rx_parser_v2 #(
    parameter int W_PKT    = 134,
    parameter int TS_W     = 48,
    parameter int SUB_W    = 17,
    parameter int SUB_MOD  = 125000,
    parameter int FIFO_AW  = 8,
    parameter int READY_TH = 192,
    parameter int PORT_W   = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inptp_data_wr,
    input  logic [W_PKT-1:0]    inptp_data,
    input  logic                inptp_valid_wr,
    input  logic                inptp_valid,
    output logic                inptp_ready,
    input  logic [TS_W-1:0]     timer,
    output logic [PORT_W+47:0]  key,
    output logic                key_valid,
    output logic [3:0]          ptp_recv_type,
    output logic                ptp_recv_type_valid,
    output logic                ts_2_record,
    output logic [TS_W-1:0]     ts_1,
    output logic                ts_1_valid,
    output logic [TS_W-1:0]     ts_4_time,
    output logic                ts_4_time_wr,
    output logic [TS_W-1:0]     ts_4,
    output logic                ts_4_valid,
    output logic [31:0]         cnt_t1,
    output logic [31:0]         cnt_t3,
    output logic [31:0]         cnt_t4,
    output logic [31:0]         cnt_drop,
    output logic [31:0]         cnt_err,
    output logic                ovf_err
);

    localparam int c_HI_W    = TS_W - SUB_W;
    localparam int c_V_AW    = FIFO_AW - 2;
    localparam int c_D_DEPTH = 1 << FIFO_AW;
    localparam int c_V_DEPTH = 1 << c_V_AW;

    localparam logic [FIFO_AW:0]   c_D_FULL   = c_D_DEPTH;
    localparam logic [FIFO_AW:0]   c_D_CNT1   = 1;
    localparam logic [FIFO_AW-1:0] c_D_PTR1   = 1;
    localparam logic [FIFO_AW:0]   c_READY_TH = READY_TH;
    localparam logic [c_V_AW:0]    c_V_FULL   = c_V_DEPTH;
    localparam logic [c_V_AW:0]    c_V_CNT1   = 1;
    localparam logic [c_V_AW-1:0]  c_V_PTR1   = 1;
    localparam logic [SUB_W:0]     c_SUB_MOD  = SUB_MOD;
    localparam logic [c_HI_W-1:0]  c_HI_ONE   = 1;

    localparam logic [3:0] c_ST_IDLE    = 4'd0;
    localparam logic [3:0] c_ST_META0   = 4'd1;
    localparam logic [3:0] c_ST_META1   = 4'd2;
    localparam logic [3:0] c_ST_ETH     = 4'd3;
    localparam logic [3:0] c_ST_PTP1    = 4'd4;
    localparam logic [3:0] c_ST_PTP2    = 4'd5;
    localparam logic [3:0] c_ST_PTP3    = 4'd6;
    localparam logic [3:0] c_ST_DRAIN   = 4'd7;
    localparam logic [3:0] c_ST_DISCARD = 4'd8;

    // ------------------------------------------------------------------------
    // Timestamp arithmetic on {hi, lo} with lo < SUB_MOD; hi wraps freely.
    // ------------------------------------------------------------------------
    function automatic logic [TS_W-1:0] ts_sub(input logic [TS_W-1:0] a,
                                               input logic [TS_W-1:0] b);
        logic [c_HI_W-1:0] hi;
        logic [SUB_W:0]    lo;
        if (a[SUB_W-1:0] >= b[SUB_W-1:0]) begin
            hi = a[TS_W-1:SUB_W] - b[TS_W-1:SUB_W];
            lo = {1'b0, a[SUB_W-1:0]} - {1'b0, b[SUB_W-1:0]};
        end else begin
            hi = a[TS_W-1:SUB_W] - b[TS_W-1:SUB_W] - c_HI_ONE;
            lo = {1'b0, a[SUB_W-1:0]} + c_SUB_MOD - {1'b0, b[SUB_W-1:0]};
        end
        return {hi, lo[SUB_W-1:0]};
    endfunction

    function automatic logic [TS_W-1:0] ts_add(input logic [TS_W-1:0] a,
                                               input logic [TS_W-1:0] b);
        logic [c_HI_W-1:0] hi;
        logic [SUB_W:0]    s;
        logic [SUB_W:0]    lo;
        s = {1'b0, a[SUB_W-1:0]} + {1'b0, b[SUB_W-1:0]};
        if (s >= c_SUB_MOD) begin
            hi = a[TS_W-1:SUB_W] + b[TS_W-1:SUB_W] + c_HI_ONE;
            lo = s - c_SUB_MOD;
        end else begin
            hi = a[TS_W-1:SUB_W] + b[TS_W-1:SUB_W];
            lo = s;
        end
        return {hi, lo[SUB_W-1:0]};
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

    // ------------------------------------------------------------------------
    // Data FIFO (show-ahead: head entry read combinationally)
    // ------------------------------------------------------------------------
    logic [W_PKT-1:0]   r_d_mem [c_D_DEPTH];
    logic [FIFO_AW-1:0] r_d_wptr;
    logic [FIFO_AW-1:0] r_d_rptr;
    logic [FIFO_AW:0]   r_d_cnt;
    logic               w_d_full;
    logic               w_d_nempty;
    logic               w_d_wr_ok;
    logic               w_d_pop;
    logic [W_PKT-1:0]   w_flit;

    assign w_d_full    = (r_d_cnt == c_D_FULL);
    assign w_d_nempty  = (r_d_cnt != '0);
    assign w_d_wr_ok   = inptp_data_wr && !w_d_full;
    assign w_flit      = r_d_mem[r_d_rptr];
    assign inptp_ready = (r_d_cnt < c_READY_TH);

    always_ff @(posedge clk) begin
        if (w_d_wr_ok) begin
            r_d_mem[r_d_wptr] <= inptp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_d_wptr <= '0;
            r_d_rptr <= '0;
            r_d_cnt  <= '0;
        end else begin
            if (w_d_wr_ok) r_d_wptr <= r_d_wptr + c_D_PTR1;
            if (w_d_pop)   r_d_rptr <= r_d_rptr + c_D_PTR1;
            // Simultaneous write and pop leave the occupancy unchanged.
            if (w_d_wr_ok && !w_d_pop)      r_d_cnt <= r_d_cnt + c_D_CNT1;
            else if (!w_d_wr_ok && w_d_pop) r_d_cnt <= r_d_cnt - c_D_CNT1;
        end
    end

    // ------------------------------------------------------------------------
    // Valid-flag FIFO
    // ------------------------------------------------------------------------
    logic              r_v_mem [c_V_DEPTH];
    logic [c_V_AW-1:0] r_v_wptr;
    logic [c_V_AW-1:0] r_v_rptr;
    logic [c_V_AW:0]   r_v_cnt;
    logic              w_v_full;
    logic              w_v_nempty;
    logic              w_v_wr_ok;
    logic              w_v_pop;
    logic              w_v_q;

    assign w_v_full   = (r_v_cnt == c_V_FULL);
    assign w_v_nempty = (r_v_cnt != '0);
    assign w_v_wr_ok  = inptp_valid_wr && !w_v_full;
    assign w_v_q      = r_v_mem[r_v_rptr];

    always_ff @(posedge clk) begin
        if (w_v_wr_ok) begin
            r_v_mem[r_v_wptr] <= inptp_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v_wptr <= '0;
            r_v_rptr <= '0;
            r_v_cnt  <= '0;
        end else begin
            if (w_v_wr_ok) r_v_wptr <= r_v_wptr + c_V_PTR1;
            if (w_v_pop)   r_v_rptr <= r_v_rptr + c_V_PTR1;
            if (w_v_wr_ok && !w_v_pop)      r_v_cnt <= r_v_cnt + c_V_CNT1;
            else if (!w_v_wr_ok && w_v_pop) r_v_cnt <= r_v_cnt - c_V_CNT1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_err <= 1'b0;
        end else if ((inptp_data_wr && w_d_full) || (inptp_valid_wr && w_v_full)) begin
            ovf_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Flit field extraction
    // ------------------------------------------------------------------------
    logic            w_tail;
    logic [3:0]      w_flit_type;
    logic [TS_W-1:0] w_cf;
    logic [TS_W-1:0] w_origin;
    logic            w_unused_flit;

    assign w_tail      = (w_flit[W_PKT-1:W_PKT-2] == 2'b10);
    assign w_flit_type = w_flit[11:8];
    // Only the low hi-width bits of the correction field survive the hi wrap.
    assign w_cf        = {w_flit[16+SUB_W +: c_HI_W], w_flit[16 +: SUB_W]};
    assign w_origin    = {w_flit[48+SUB_W +: c_HI_W], w_flit[48 +: SUB_W]};
    assign w_unused_flit = &{1'b0, w_flit};

    // ------------------------------------------------------------------------
    // Parse FSM
    // ------------------------------------------------------------------------
    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_trunc;

    always_ff @(posedge clk) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE:    if (w_v_nempty) w_next = w_v_q ? c_ST_META0 : c_ST_DISCARD;
            c_ST_META0:   if (w_d_nempty) w_next = w_tail ? c_ST_IDLE : c_ST_META1;
            c_ST_META1:   if (w_d_nempty) w_next = w_tail ? c_ST_IDLE : c_ST_ETH;
            c_ST_ETH:     if (w_d_nempty) w_next = w_tail ? c_ST_IDLE : c_ST_PTP1;
            c_ST_PTP1:    if (w_d_nempty) w_next = w_tail ? c_ST_IDLE : c_ST_PTP2;
            c_ST_PTP2:    if (w_d_nempty) w_next = w_tail ? c_ST_IDLE : c_ST_PTP3;
            c_ST_PTP3:    if (w_d_nempty) w_next = w_tail ? c_ST_IDLE : c_ST_DRAIN;
            c_ST_DRAIN,
            c_ST_DISCARD: if (w_d_nempty && w_tail) w_next = c_ST_IDLE;
            default:      w_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_v_pop = 1'b0;
        w_d_pop = 1'b0;
        w_trunc = 1'b0;
        if (r_state == c_ST_IDLE) w_v_pop = w_v_nempty;
        else                      w_d_pop = w_d_nempty;
        case (r_state)
            c_ST_META0, c_ST_META1, c_ST_ETH, c_ST_PTP1, c_ST_PTP2:
                w_trunc = w_d_pop && w_tail;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Field capture, timestamp pipeline, outputs and counters
    // ------------------------------------------------------------------------
    logic [TS_W-1:0]   r_meta_ts;
    logic [TS_W-1:0]   r_rx_timer;
    logic [PORT_W-1:0] r_in_port;
    logic [3:0]        r_type;
    logic [TS_W-1:0]   r_md;
    logic [TS_W-1:0]   r_corr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta_ts           <= '0;
            r_rx_timer          <= '0;
            r_in_port           <= '0;
            r_type              <= '0;
            r_md                <= '0;
            r_corr              <= '0;
            key                 <= '0;
            key_valid           <= 1'b0;
            ptp_recv_type       <= '0;
            ptp_recv_type_valid <= 1'b0;
            ts_2_record         <= 1'b0;
            ts_1                <= '0;
            ts_1_valid          <= 1'b0;
            ts_4_time           <= '0;
            ts_4_time_wr        <= 1'b0;
            ts_4                <= '0;
            ts_4_valid          <= 1'b0;
            cnt_t1              <= '0;
            cnt_t3              <= '0;
            cnt_t4              <= '0;
            cnt_drop            <= '0;
            cnt_err             <= '0;
        end else begin
            key_valid           <= 1'b0;
            ptp_recv_type_valid <= 1'b0;
            ts_2_record         <= 1'b0;
            ts_1_valid          <= 1'b0;
            ts_4_time_wr        <= 1'b0;
            ts_4_valid          <= 1'b0;

            // A discarded packet is counted once, when its flag is popped.
            if (w_v_pop && !w_v_q) cnt_drop <= sat_inc(cnt_drop);

            if (w_d_pop) begin
                case (r_state)
                    c_ST_META0: begin
                        r_meta_ts  <= w_flit[TS_W-1:0];
                        r_in_port  <= w_flit[120 +: PORT_W];
                        r_rx_timer <= timer;
                    end
                    c_ST_ETH: begin
                        r_type <= w_flit_type;
                        r_md   <= ts_sub(r_rx_timer, r_meta_ts);
                        if (w_flit_type == 4'd1 || w_flit_type == 4'd3) begin
                            key                 <= {w_flit[79:32], r_in_port};
                            key_valid           <= 1'b1;
                            ptp_recv_type       <= w_flit_type;
                            ptp_recv_type_valid <= 1'b1;
                        end
                        case (w_flit_type)
                            4'd1: begin
                                ts_2_record <= 1'b1;
                                cnt_t1      <= sat_inc(cnt_t1);
                            end
                            4'd3:    cnt_t3 <= sat_inc(cnt_t3);
                            4'd4:    cnt_t4 <= sat_inc(cnt_t4);
                            default: ;
                        endcase
                    end
                    c_ST_PTP1: r_corr <= ts_add(r_md, w_cf);
                    c_ST_PTP3: begin
                        case (r_type)
                            4'd1: begin
                                ts_1       <= ts_add(r_corr, w_origin);
                                ts_1_valid <= 1'b1;
                            end
                            4'd3: begin
                                ts_4_time    <= ts_sub(r_rx_timer, r_corr);
                                ts_4_time_wr <= 1'b1;
                            end
                            4'd4: begin
                                ts_4                <= w_origin;
                                ts_4_valid          <= 1'b1;
                                ptp_recv_type       <= r_type;
                                ptp_recv_type_valid <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end

            if (w_trunc) cnt_err <= sat_inc(cnt_err);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ptp_rx_parser_v2.sv
`default_nettype none
// ============================================================================
// Module   : tb_ptp_rx_parser_v2
// Purpose  : Scoreboard bench for ptp_rx_parser_v2. Stimulus pushes the
//            hand-computed expected pulse events (with their cycle) into a
//            queue; a negedge monitor pops one entry per pulsing cycle.
// Revision : 1.0 - initial bench
// ============================================================================
module tb_ptp_rx_parser_v2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         inptp_data_wr = 1'b0;
    logic [133:0] inptp_data = '0;
    logic         inptp_valid_wr = 1'b0;
    logic         inptp_valid = 1'b0;
    logic         inptp_ready;
    logic [47:0]  timer = '0;
    logic [53:0]  key;
    logic         key_valid;
    logic [3:0]   ptp_recv_type;
    logic         ptp_recv_type_valid;
    logic         ts_2_record;
    logic [47:0]  ts_1;
    logic         ts_1_valid;
    logic [47:0]  ts_4_time;
    logic         ts_4_time_wr;
    logic [47:0]  ts_4;
    logic         ts_4_valid;
    logic [31:0]  cnt_t1, cnt_t3, cnt_t4, cnt_drop, cnt_err;
    logic         ovf_err;

    ptp_rx_parser_v2 dut (
        .clk                 (clk),
        .reset               (reset),
        .inptp_data_wr       (inptp_data_wr),
        .inptp_data          (inptp_data),
        .inptp_valid_wr      (inptp_valid_wr),
        .inptp_valid         (inptp_valid),
        .inptp_ready         (inptp_ready),
        .timer               (timer),
        .key                 (key),
        .key_valid           (key_valid),
        .ptp_recv_type       (ptp_recv_type),
        .ptp_recv_type_valid (ptp_recv_type_valid),
        .ts_2_record         (ts_2_record),
        .ts_1                (ts_1),
        .ts_1_valid          (ts_1_valid),
        .ts_4_time           (ts_4_time),
        .ts_4_time_wr        (ts_4_time_wr),
        .ts_4                (ts_4),
        .ts_4_valid          (ts_4_valid),
        .cnt_t1              (cnt_t1),
        .cnt_t3              (cnt_t3),
        .cnt_t4              (cnt_t4),
        .cnt_drop            (cnt_drop),
        .cnt_err             (cnt_err),
        .ovf_err             (ovf_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // pulses = {key_valid, ptp_recv_type_valid, ts_2_record, ts_1_valid, ts_4_time_wr, ts_4_valid}
    typedef struct {
        logic [5:0]  pulses;
        logic [53:0] key;
        logic [3:0]  typ;
        logic [47:0] ts;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [5:0] p, input logic [53:0] k, input logic [3:0] t,
                        input logic [47:0] ts, input int c);
        exp_t e;
        e.pulses = p; e.key = k; e.typ = t; e.ts = ts; e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Monitor: one scoreboard entry per cycle with any result pulse.
    logic [5:0] mon_p;
    exp_t       mon_e;
    always @(negedge clk) begin
        if (!reset) begin
            mon_p = {key_valid, ptp_recv_type_valid, ts_2_record, ts_1_valid, ts_4_time_wr, ts_4_valid};
            if (mon_p != 6'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got pulses %b at cycle %0d, expected none", mon_p, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pulses", 64'(mon_p), 64'(mon_e.pulses));
                    chk("pulse_cycle", 64'(cyc), 64'(mon_e.cyc));
                    if (mon_e.pulses[5]) begin
                        chk("key", 64'(key), 64'(mon_e.key));
                        chk("ptp_recv_type", 64'(ptp_recv_type), 64'(mon_e.typ));
                    end
                    if (mon_e.pulses[2]) chk("ts_1", 64'(ts_1), 64'(mon_e.ts));
                    if (mon_e.pulses[1]) chk("ts_4_time", 64'(ts_4_time), 64'(mon_e.ts));
                    if (mon_e.pulses[0]) begin
                        chk("ts_4", 64'(ts_4), 64'(mon_e.ts));
                        chk("ptp_recv_type_t4", 64'(ptp_recv_type), 64'(mon_e.typ));
                    end
                end
            end
        end
    end

    function automatic logic [47:0] mk_ts(input int hi, input int lo);
        return {hi[30:0], lo[16:0]};
    endfunction

    function automatic logic [133:0] pkt_flit(input int idx, input int n, input logic [3:0] typ,
                                              input logic [5:0] port, input logic [47:0] smac,
                                              input logic [47:0] meta, input logic [47:0] cf,
                                              input logic [47:0] origin);
        logic [133:0] f;
        f = '0;
        case (idx)
            0: begin f[47:0] = meta; f[125:120] = port; end
            2: begin f[79:32] = smac; f[11:8] = typ; end
            3: begin f[63:33] = cf[47:17]; f[32:16] = cf[16:0]; end
            5: begin f[95:65] = origin[47:17]; f[64:48] = origin[16:0]; end
            default: ;
        endcase
        if (idx == 0)          f[133:132] = 2'b01;
        else if (idx == n - 1) f[133:132] = 2'b10;
        else                   f[133:132] = 2'b11;
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr_flit(input logic [133:0] f);
        inptp_data_wr = 1'b1;
        inptp_data    = f;
        step();
        inptp_data_wr = 1'b0;
    endtask

    // Returns the cycle in which the flag is written; it is popped one cycle later.
    task automatic wr_flag(input logic v, output int c);
        c = cyc;
        inptp_valid_wr = 1'b1;
        inptp_valid    = v;
        step();
        inptp_valid_wr = 1'b0;
    endtask

    task automatic send_full(input int n, input logic [3:0] typ, input logic [5:0] port,
                             input logic [47:0] smac, input logic [47:0] meta,
                             input logic [47:0] cf, input logic [47:0] origin,
                             input logic flag, output int c);
        for (int i = 0; i < n; i++) wr_flit(pkt_flit(i, n, typ, port, smac, meta, cf, origin));
        wr_flag(flag, c);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_key"}, 64'(key), 64'd0);
        chk({tag, "_pulses"}, 64'({key_valid, ptp_recv_type_valid, ts_2_record,
                                   ts_1_valid, ts_4_time_wr, ts_4_valid}), 64'd0);
        chk({tag, "_type"}, 64'(ptp_recv_type), 64'd0);
        chk({tag, "_ts_1"}, 64'(ts_1), 64'd0);
        chk({tag, "_ts_4_time"}, 64'(ts_4_time), 64'd0);
        chk({tag, "_ts_4"}, 64'(ts_4), 64'd0);
        chk({tag, "_cnt_t1"}, 64'(cnt_t1), 64'd0);
        chk({tag, "_cnt_t3"}, 64'(cnt_t3), 64'd0);
        chk({tag, "_cnt_t4"}, 64'(cnt_t4), 64'd0);
        chk({tag, "_cnt_drop"}, 64'(cnt_drop), 64'd0);
        chk({tag, "_cnt_err"}, 64'(cnt_err), 64'd0);
        chk({tag, "_ovf_err"}, 64'(ovf_err), 64'd0);
        chk({tag, "_ready"}, 64'(inptp_ready), 64'd1);
    endtask

    localparam logic [47:0] SMAC_A = 48'h0011_2233_4455;
    localparam logic [47:0] SMAC_B = 48'hAABB_CCDD_EEFF;
    localparam logic [47:0] SMAC_C = 48'h1234_5678_9ABC;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin : stim
        int c;
        int cf;
        logic [47:0] ts_t1_res;
        ts_t1_res = mk_ts(6, 200);

        // Reset state
        idle(3);
        chk_all_zero("reset");
        reset = 1'b0;
        step();

        // Type 1: md={0,500}, corr={0,700}, ts_1={0,700}+{5,124500}={6,200}
        timer = mk_ts(10, 1500);
        send_full(6, 4'd1, 6'h2A, SMAC_A, mk_ts(10, 1000), mk_ts(0, 200), mk_ts(5, 124500), 1'b1, c);
        push(6'b111000, {SMAC_A, 6'h2A}, 4'd1, '0, c + 5);
        push(6'b000100, '0, 4'd0, ts_t1_res, c + 8);
        idle(15);
        chk("t1_cnt_t1", 64'(cnt_t1), 64'd1);

        // Type 3 with borrow: md={0,1100}, ts_4_time={21,100}-{0,1100}={20,124000}
        timer = mk_ts(21, 100);
        send_full(6, 4'd3, 6'h05, SMAC_B, mk_ts(20, 124000), mk_ts(0, 0), mk_ts(0, 0), 1'b1, c);
        push(6'b110000, {SMAC_B, 6'h05}, 4'd3, '0, c + 5);
        push(6'b000010, '0, 4'd0, mk_ts(20, 124000), c + 8);
        idle(15);
        chk("t3_cnt_t3", 64'(cnt_t3), 64'd1);

        // Discard then type 4
        send_full(4, 4'd1, 6'h01, SMAC_A, mk_ts(1, 1), mk_ts(0, 0), mk_ts(0, 0), 1'b0, c);
        idle(10);
        chk("disc_cnt_drop", 64'(cnt_drop), 64'd1);
        send_full(6, 4'd4, 6'h11, SMAC_C, mk_ts(3, 3), mk_ts(0, 0), mk_ts(7, 3), 1'b1, c);
        push(6'b010001, '0, 4'd4, mk_ts(7, 3), c + 8);
        idle(15);
        chk("t4_cnt_t4", 64'(cnt_t4), 64'd1);

        // Stall before flit 4 and drain of an 8-flit packet
        timer = mk_ts(10, 1500);
        for (int i = 0; i < 4; i++)
            wr_flit(pkt_flit(i, 8, 4'd1, 6'h2A, SMAC_A, mk_ts(10, 1000), mk_ts(0, 200), mk_ts(5, 124500)));
        wr_flag(1'b1, cf);
        push(6'b111000, {SMAC_A, 6'h2A}, 4'd1, '0, cf + 5);
        push(6'b000100, '0, 4'd0, ts_t1_res, cf + 11);
        while (cyc < cf + 8) step();
        for (int i = 4; i < 8; i++)
            wr_flit(pkt_flit(i, 8, 4'd1, 6'h2A, SMAC_A, mk_ts(10, 1000), mk_ts(0, 200), mk_ts(5, 124500)));
        idle(15);
        chk("stall_cnt_t1", 64'(cnt_t1), 64'd2);

        // Truncated type 3 (tail at flit 3), then a good type 1
        timer = mk_ts(21, 100);
        send_full(4, 4'd3, 6'h05, SMAC_B, mk_ts(20, 124000), mk_ts(0, 0), mk_ts(0, 0), 1'b1, c);
        push(6'b110000, {SMAC_B, 6'h05}, 4'd3, '0, c + 5);
        idle(12);
        chk("trunc_cnt_err", 64'(cnt_err), 64'd1);
        timer = mk_ts(10, 1500);
        send_full(6, 4'd1, 6'h2A, SMAC_A, mk_ts(10, 1000), mk_ts(0, 200), mk_ts(5, 124500), 1'b1, c);
        push(6'b111000, {SMAC_A, 6'h2A}, 4'd1, '0, c + 5);
        push(6'b000100, '0, 4'd0, ts_t1_res, c + 8);
        idle(15);
        chk("trunc_cnt_t1", 64'(cnt_t1), 64'd3);
        chk("trunc_cnt_t3", 64'(cnt_t3), 64'd2);

        // Overflow: 2^8+1 middle flits with no flag, so nothing is read
        for (int i = 1; i <= 257; i++) begin
            wr_flit({2'b11, 132'd0});
            if (i == 191) chk("ovf_ready_191", 64'(inptp_ready), 64'd1);
            if (i == 192) chk("ovf_ready_192", 64'(inptp_ready), 64'd0);
            if (i == 256) chk("ovf_err_256", 64'(ovf_err), 64'd0);
        end
        chk("ovf_err_257", 64'(ovf_err), 64'd1);
        chk("ovf_ready_257", 64'(inptp_ready), 64'd0);

        // Start a parse of the junk, then reset mid-packet
        wr_flag(1'b1, c);
        idle(3);
        chk("ovf_err_sticky", 64'(ovf_err), 64'd1);
        reset = 1'b1;
        step();
        chk_all_zero("midreset");
        reset = 1'b0;
        step();
        chk_all_zero("postreset");
        idle(5);

        // FIFOs were flushed: a fresh packet parses cleanly
        send_full(6, 4'd1, 6'h2A, SMAC_A, mk_ts(10, 1000), mk_ts(0, 200), mk_ts(5, 124500), 1'b1, c);
        push(6'b111000, {SMAC_A, 6'h2A}, 4'd1, '0, c + 5);
        push(6'b000100, '0, 4'd0, ts_t1_res, c + 8);
        idle(15);
        chk("final_cnt_t1", 64'(cnt_t1), 64'd1);
        chk("scoreboard_left", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
